// File: rtl/reg_file_multiport.sv
// Multiport MIPS decode-stage register file: general, link and hi/lo write ports,
// combinational read ports with optional same-cycle write-through, and a pending-write scoreboard.
module reg_file_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2,
  parameter int LINK_REG   = 31,
  parameter int BYPASS     = 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_id,
  input  logic [NUM_READ-1:0]              rd_used,
  output logic [NUM_READ*DATA_WIDTH-1:0]   rd_value,
  output logic [NUM_READ-1:0]              rd_busy,
  output logic                             stall,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_id,
  input  logic [DATA_WIDTH-1:0]            wr_value,
  input  logic                             link_en,
  input  logic [DATA_WIDTH-1:0]            link_value,
  input  logic                             hilo_en,
  input  logic [DATA_WIDTH-1:0]            hi_value,
  input  logic [DATA_WIDTH-1:0]            lo_value,
  output logic [DATA_WIDTH-1:0]            hi_out,
  output logic [DATA_WIDTH-1:0]            lo_out,
  input  logic                             issue_en,
  input  logic [ADDR_WIDTH-1:0]            issue_id,
  output logic [DATA_WIDTH-1:0]            syscall_funct,
  output logic [DATA_WIDTH-1:0]            syscall_param1
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ID_V0 = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ID_A0 = ADDR_WIDTH'(4);
  localparam logic BYPASS_ON = (BYPASS != 0);

  logic [DATA_WIDTH-1:0] regs_r [DEPTH];
  logic [DEPTH-1:0]      busy_r;
  logic [DATA_WIDTH-1:0] hi_r;
  logic [DATA_WIDTH-1:0] lo_r;

  // Effective write per register; doubles as the scoreboard clear.
  logic [DEPTH-1:0]      we_s;
  logic [DATA_WIDTH-1:0] wdata_s [DEPTH];
  logic [DEPTH-1:0]      set_s;
  logic [ADDR_WIDTH-1:0] id_s [NUM_READ];

  // Resolve link/write-back priority and scoreboard set for every register.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      we_s[r]    = 1'b0;
      wdata_s[r] = '0;
      set_s[r]   = 1'b0;
      if (r != 0) begin
        if (link_en && (r == LINK_REG)) begin
          we_s[r]    = 1'b1;
          wdata_s[r] = link_value;
        end else if (wr_en && (wr_id == ADDR_WIDTH'(r))) begin
          we_s[r]    = 1'b1;
          wdata_s[r] = wr_value;
        end else begin
          we_s[r]    = 1'b0;
        end
        set_s[r] = issue_en && (issue_id == ADDR_WIDTH'(r));
      end else begin
        set_s[r] = 1'b0;
      end
    end
  end

  // Register, hi/lo and scoreboard state; a new issue outranks a same-cycle clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_r[r] <= '0;
      end
      busy_r <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (we_s[r]) begin
          regs_r[r] <= wdata_s[r];
        end
        if (set_s[r]) begin
          busy_r[r] <= 1'b1;
        end else if (we_s[r]) begin
          busy_r[r] <= 1'b0;
        end
      end
      if (hilo_en) begin
        hi_r <= hi_value;
        lo_r <= lo_value;
      end
    end
  end

  // Read ports: a forwarded write also hides the busy bit it is about to clear.
  always_comb begin
    rd_value = '0;
    rd_busy  = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      id_s[k] = rd_id[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (BYPASS_ON && we_s[id_s[k]]) begin
        rd_value[k*DATA_WIDTH +: DATA_WIDTH] = wdata_s[id_s[k]];
        rd_busy[k] = 1'b0;
      end else begin
        rd_value[k*DATA_WIDTH +: DATA_WIDTH] = regs_r[id_s[k]];
        rd_busy[k] = busy_r[id_s[k]];
      end
    end
    stall = |(rd_busy & rd_used);
  end

  // Special-purpose outputs follow the same forwarding rule as the read ports.
  always_comb begin
    if (BYPASS_ON && hilo_en) begin
      hi_out = hi_value;
      lo_out = lo_value;
    end else begin
      hi_out = hi_r;
      lo_out = lo_r;
    end
    if (BYPASS_ON && we_s[ID_V0]) begin
      syscall_funct = wdata_s[ID_V0];
    end else begin
      syscall_funct = regs_r[ID_V0];
    end
    if (BYPASS_ON && we_s[ID_A0]) begin
      syscall_param1 = wdata_s[ID_A0];
    end else begin
      syscall_param1 = regs_r[ID_A0];
    end
  end

endmodule

// File: tb/tb_reg_file_multiport.sv
// Directed bench for reg_file_multiport: a forwarding instance and a stored-value-only
// instance share stimulus; a cycle table plus hand sequences cover the corner cases.
module tb_reg_file_multiport;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rd_id;
  logic [1:0]  rd_used;
  logic        wr_en;
  logic [4:0]  wr_id;
  logic [31:0] wr_value;
  logic        link_en;
  logic [31:0] link_value;
  logic        hilo_en;
  logic [31:0] hi_value, lo_value;
  logic        issue_en;
  logic [4:0]  issue_id;

  logic [63:0] a_rd_value, b_rd_value;
  logic [1:0]  a_rd_busy, b_rd_busy;
  logic        a_stall, b_stall;
  logic [31:0] a_hi, a_lo, b_hi, b_lo;
  logic [31:0] a_sf, a_sp, b_sf, b_sp;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  reg_file_multiport #(.BYPASS(1)) dut_a (
    .clock(clock), .reset(reset), .rd_id(rd_id), .rd_used(rd_used),
    .rd_value(a_rd_value), .rd_busy(a_rd_busy), .stall(a_stall),
    .wr_en(wr_en), .wr_id(wr_id), .wr_value(wr_value),
    .link_en(link_en), .link_value(link_value),
    .hilo_en(hilo_en), .hi_value(hi_value), .lo_value(lo_value),
    .hi_out(a_hi), .lo_out(a_lo), .issue_en(issue_en), .issue_id(issue_id),
    .syscall_funct(a_sf), .syscall_param1(a_sp)
  );

  reg_file_multiport #(.BYPASS(0)) dut_b (
    .clock(clock), .reset(reset), .rd_id(rd_id), .rd_used(rd_used),
    .rd_value(b_rd_value), .rd_busy(b_rd_busy), .stall(b_stall),
    .wr_en(wr_en), .wr_id(wr_id), .wr_value(wr_value),
    .link_en(link_en), .link_value(link_value),
    .hilo_en(hilo_en), .hi_value(hi_value), .lo_value(lo_value),
    .hi_out(b_hi), .lo_out(b_lo), .issue_en(issue_en), .issue_id(issue_id),
    .syscall_funct(b_sf), .syscall_param1(b_sp)
  );

  typedef struct {
    logic        we;  logic [4:0]  wid; logic [31:0] wv;
    logic        le;  logic [31:0] lv;
    logic        he;  logic [31:0] hv;  logic [31:0] lov;
    logic        ie;  logic [4:0]  iid;
    logic [4:0]  r0;  logic [4:0]  r1;  logic [1:0]  used;
    logic [31:0] e0;  logic [31:0] e1;  logic [31:0] es0;
    logic [1:0]  ebusy; logic estall;
    logic [31:0] ehi; logic [31:0] elo;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(
    input logic we, input logic [4:0] wid, input logic [31:0] wv,
    input logic le, input logic [31:0] lv,
    input logic he, input logic [31:0] hv, input logic [31:0] lov,
    input logic ie, input logic [4:0] iid,
    input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] used,
    input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] es0,
    input logic [1:0] ebusy, input logic estall,
    input logic [31:0] ehi, input logic [31:0] elo);
    vec_t v;
    v.we = we; v.wid = wid; v.wv = wv; v.le = le; v.lv = lv;
    v.he = he; v.hv = hv; v.lov = lov; v.ie = ie; v.iid = iid;
    v.r0 = r0; v.r1 = r1; v.used = used;
    v.e0 = e0; v.e1 = e1; v.es0 = es0; v.ebusy = ebusy; v.estall = estall;
    v.ehi = ehi; v.elo = elo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; rd_id = '0; rd_used = 2'b00;
    wr_en = 1'b0; wr_id = 5'd0; wr_value = 32'h0;
    link_en = 1'b0; link_value = 32'h0;
    hilo_en = 1'b0; hi_value = 32'h0; lo_value = 32'h0;
    issue_en = 1'b0; issue_id = 5'd0;
  endtask

  initial begin
    // we wid wv | le lv | he hi lo | ie iid | r0 r1 used | e0 e1 es0 | busy stall | hi lo
    vecs[0]  = mk(1'b1,5'd0,32'hFFFFFFFF, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,5'd0, 5'd0,5'd0,2'b11, 32'h0,32'h0,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[1]  = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd0,5'd0,2'b11, 32'h0,32'h0,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[2]  = mk(1'b1,5'd9,32'hDEADBEEF, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd9,5'd8,2'b00, 32'hDEADBEEF,32'h0,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[3]  = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd9,5'd8,2'b00, 32'hDEADBEEF,32'h0,32'hDEADBEEF, 2'b00,1'b0, 32'h0,32'h0);
    vecs[4]  = mk(1'b1,5'd31,32'hA, 1'b1,32'hB, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd31,5'd9,2'b00, 32'hB,32'hDEADBEEF,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[5]  = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd31,5'd9,2'b00, 32'hB,32'hDEADBEEF,32'hB, 2'b00,1'b0, 32'h0,32'h0);
    vecs[6]  = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,5'd5, 5'd5,5'd0,2'b01, 32'h0,32'h0,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[7]  = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd5,5'd0,2'b01, 32'h0,32'h0,32'h0, 2'b01,1'b1, 32'h0,32'h0);
    vecs[8]  = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd5,5'd0,2'b01, 32'h0,32'h0,32'h0, 2'b01,1'b1, 32'h0,32'h0);
    vecs[9]  = mk(1'b1,5'd5,32'h77, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd5,5'd0,2'b01, 32'h77,32'h0,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[10] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd5,5'd0,2'b01, 32'h77,32'h0,32'h77, 2'b00,1'b0, 32'h0,32'h0);
    vecs[11] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,5'd6, 5'd6,5'd5,2'b00, 32'h0,32'h77,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[12] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd6,5'd5,2'b00, 32'h0,32'h77,32'h0, 2'b01,1'b0, 32'h0,32'h0);
    vecs[13] = mk(1'b1,5'd6,32'h55, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,5'd6, 5'd6,5'd5,2'b01, 32'h55,32'h77,32'h0, 2'b00,1'b0, 32'h0,32'h0);
    vecs[14] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd6,5'd5,2'b01, 32'h55,32'h77,32'h55, 2'b01,1'b1, 32'h0,32'h0);
    vecs[15] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b1,32'h1,32'h2, 1'b0,5'd0, 5'd0,5'd6,2'b10, 32'h0,32'h55,32'h0, 2'b10,1'b1, 32'h1,32'h2);
    vecs[16] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd0,5'd6,2'b00, 32'h0,32'h55,32'h0, 2'b10,1'b0, 32'h1,32'h2);
    vecs[17] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b1,5'd31, 5'd31,5'd6,2'b01, 32'hB,32'h55,32'hB, 2'b10,1'b0, 32'h1,32'h2);
    vecs[18] = mk(1'b0,5'd0,32'h0, 1'b1,32'hC, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd31,5'd6,2'b01, 32'hC,32'h55,32'hB, 2'b10,1'b0, 32'h1,32'h2);
    vecs[19] = mk(1'b0,5'd0,32'h0, 1'b0,32'h0, 1'b0,32'h0,32'h0, 1'b0,5'd0, 5'd31,5'd6,2'b11, 32'hC,32'h55,32'hC, 2'b10,1'b1, 32'h1,32'h2);

    idle();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("reset_hi", a_hi, 32'h0);
    check("reset_lo", a_lo, 32'h0);
    check("reset_busy", {30'h0, a_rd_busy}, 32'h0);
    check("reset_stall", {31'h0, a_stall}, 32'h0);

    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      wr_en = vecs[i].we; wr_id = vecs[i].wid; wr_value = vecs[i].wv;
      link_en = vecs[i].le; link_value = vecs[i].lv;
      hilo_en = vecs[i].he; hi_value = vecs[i].hv; lo_value = vecs[i].lov;
      issue_en = vecs[i].ie; issue_id = vecs[i].iid;
      rd_id = {vecs[i].r1, vecs[i].r0}; rd_used = vecs[i].used;
      #1;
      check($sformatf("v%0d_rd0", i), a_rd_value[31:0], vecs[i].e0);
      check($sformatf("v%0d_rd1", i), a_rd_value[63:32], vecs[i].e1);
      check($sformatf("v%0d_rd0_nobyp", i), b_rd_value[31:0], vecs[i].es0);
      check($sformatf("v%0d_busy", i), {30'h0, a_rd_busy}, {30'h0, vecs[i].ebusy});
      check($sformatf("v%0d_stall", i), {31'h0, a_stall}, {31'h0, vecs[i].estall});
      check($sformatf("v%0d_hi", i), a_hi, vecs[i].ehi);
      check($sformatf("v%0d_lo", i), a_lo, vecs[i].elo);
    end

    // hi/lo forwarding only in the bypassing instance
    @(negedge clock);
    idle();
    hilo_en = 1'b1; hi_value = 32'h7; lo_value = 32'h8;
    #1;
    check("hilo_byp_hi", a_hi, 32'h7);
    check("hilo_nobyp_hi", b_hi, 32'h1);
    check("hilo_nobyp_lo", b_lo, 32'h2);
    @(negedge clock);
    idle();
    #1;
    check("hilo_stored_hi", b_hi, 32'h7);
    check("hilo_stored_lo", b_lo, 32'h8);

    // syscall outputs track r2 and r4
    @(negedge clock);
    idle();
    wr_en = 1'b1; wr_id = 5'd2; wr_value = 32'd10;
    #1;
    check("sys_funct_byp", a_sf, 32'd10);
    check("sys_funct_nobyp", b_sf, 32'd0);
    @(negedge clock);
    idle();
    wr_en = 1'b1; wr_id = 5'd4; wr_value = 32'h44;
    #1;
    check("sys_funct_stored", b_sf, 32'd10);
    check("sys_param_byp", a_sp, 32'h44);
    check("sys_param_nobyp", b_sp, 32'h0);
    @(negedge clock);
    idle();
    #1;
    check("sys_param_stored", b_sp, 32'h44);

    // reset clears data, hi/lo and busy (r6 is still pending here)
    @(negedge clock);
    idle();
    wr_en = 1'b1; wr_id = 5'd8; wr_value = 32'h1234;
    @(negedge clock);
    idle();
    reset = 1'b1;
    wr_en = 1'b1; wr_id = 5'd9; wr_value = 32'h5;
    rd_id = {5'd6, 5'd8};
    #1;
    check("pre_reset_r8", b_rd_value[31:0], 32'h1234);
    @(negedge clock);
    idle();
    rd_id = {5'd9, 5'd8}; rd_used = 2'b11;
    #1;
    check("post_reset_r8", a_rd_value[31:0], 32'h0);
    check("post_reset_r9", a_rd_value[63:32], 32'h0);
    check("post_reset_hi", a_hi, 32'h0);
    check("post_reset_lo", a_lo, 32'h0);
    check("post_reset_sys", a_sf, 32'h0);
    rd_id = {5'd31, 5'd6};
    #1;
    check("post_reset_busy", {30'h0, a_rd_busy}, 32'h0);
    check("post_reset_stall", {31'h0, a_stall}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
